// File: rtl/stack_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : stack_pkg                                                  |
// | Purpose  : Shared widths, FSM states and op decode for the LIFO stack |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
package stack_pkg;

    localparam int c_data_w = 16;
    localparam int c_depth  = 16;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_ERROR = 1'b1
    } state_t;

    // Encoding is literally {push, pop}
    typedef enum logic [1:0] {
        OP_NOP     = 2'b00,
        OP_POP     = 2'b01,
        OP_PUSH    = 2'b10,
        OP_REPLACE = 2'b11
    } op_t;

    function automatic op_t decode_op(input logic push, input logic pop);
        return op_t'({push, pop});
    endfunction

endpackage
`default_nettype wire

// File: rtl/stack_unit_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : stack_unit_if                                              |
// | Purpose  : Control-unit <-> operand stack strobes and status bundle   |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
interface stack_unit_if
    import stack_pkg::*;
#(
    parameter int DATA_W = c_data_w,
    parameter int CNT_W  = $clog2(c_depth) + 1
);
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] data_in;
    logic              clear_err;
    logic [DATA_W-1:0] top;
    logic [DATA_W-1:0] nos;
    logic              nos_valid;
    logic [CNT_W-1:0]  count;
    logic              empty;
    logic              full;
    logic              overflow;
    logic              underflow;
    logic              err;

    modport master (
        output push, pop, data_in, clear_err,
        input  top, nos, nos_valid, count, empty, full, overflow, underflow, err
    );

    modport slave (
        input  push, pop, data_in, clear_err,
        output top, nos, nos_valid, count, empty, full, overflow, underflow, err
    );

endinterface
`default_nettype wire

// File: rtl/stack_regfile.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : stack_regfile                                              |
// | Purpose  : Stack storage, 1 write / 2 async read ports. Second read   |
// |            port exists only when STACK_PEEK2_EN is defined.           |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module stack_regfile
    import stack_pkg::*;
#(
    parameter int DATA_W = c_data_w,
    parameter int DEPTH  = c_depth,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  wire logic              clock,
    input  wire logic              we,
    input  wire logic [ADDR_W-1:0] waddr,
    input  wire logic [DATA_W-1:0] wdata,
    input  wire logic [ADDR_W-1:0] raddr0,
    input  wire logic [ADDR_W-1:0] raddr1,
    output logic      [DATA_W-1:0] rdata0,
    output logic      [DATA_W-1:0] rdata1
);

    // Contents are intentionally not reset; occupancy alone defines validity
    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata0 = r_mem[raddr0];

`ifdef STACK_PEEK2_EN
    assign rdata1 = r_mem[raddr1];
`else
    logic w_unused_raddr1;
    assign w_unused_raddr1 = ^raddr1;
    assign rdata1          = '0;
`endif

endmodule
`default_nettype wire

// File: rtl/stack_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : stack_unit                                                 |
// | Purpose  : Operand LIFO with occupancy, sticky over/underflow and a   |
// |            RUN/ERROR FSM. STACK_PEEK2_EN enables the next-on-stack    |
// |            read port.                                                 |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module stack_unit
    import stack_pkg::*;
#(
    parameter int DATA_W = c_data_w,
    parameter int DEPTH  = c_depth,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  wire logic   clock,
    input  wire logic   reset,
    stack_unit_if.slave bus
);

    localparam int               ADDR_W     = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] C_FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_nxt;
    logic               r_overflow;
    logic               w_overflow_nxt;
    logic               r_underflow;
    logic               w_underflow_nxt;

    op_t                w_op;
    logic               w_empty;
    logic               w_full;
    logic               w_we;
    logic [ADDR_W-1:0]  w_waddr;
    logic [ADDR_W-1:0]  w_raddr0;
    logic [ADDR_W-1:0]  w_raddr1;
    logic [DATA_W-1:0]  w_rdata0;
    logic [DATA_W-1:0]  w_rdata1;

    assign w_op     = decode_op(bus.push, bus.pop);
    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == C_FULL_CNT);
    // Low bits only; the empty/full guards keep the wrapped values unused
    assign w_raddr0 = r_count[ADDR_W-1:0] - ADDR_W'(1);
    assign w_raddr1 = r_count[ADDR_W-1:0] - ADDR_W'(2);

    always_comb begin
        w_state_nxt     = r_state;
        w_count_nxt     = r_count;
        w_overflow_nxt  = r_overflow;
        w_underflow_nxt = r_underflow;
        w_we            = 1'b0;
        w_waddr         = r_count[ADDR_W-1:0];

        unique case (r_state)
            ST_RUN: begin
                if (bus.clear_err) begin
                    w_overflow_nxt  = 1'b0;
                    w_underflow_nxt = 1'b0;
                end
                // Fault assignments come last so they win over clear_err
                unique case (w_op)
                    OP_PUSH: begin
                        if (w_full) begin
                            w_overflow_nxt = 1'b1;
                            w_state_nxt    = ST_ERROR;
                        end else begin
                            w_we        = 1'b1;
                            w_count_nxt = r_count + C_ONE;
                        end
                    end
                    OP_POP: begin
                        if (w_empty) begin
                            w_underflow_nxt = 1'b1;
                            w_state_nxt     = ST_ERROR;
                        end else begin
                            w_count_nxt = r_count - C_ONE;
                        end
                    end
                    OP_REPLACE: begin
                        w_we = 1'b1;
                        if (w_empty) begin
                            w_count_nxt     = C_ONE;
                            w_underflow_nxt = 1'b1;
                            w_state_nxt     = ST_ERROR;
                        end else begin
                            w_waddr = w_raddr0;
                        end
                    end
                    default: ;
                endcase
            end
            ST_ERROR: begin
                if (bus.clear_err) begin
                    w_state_nxt     = ST_RUN;
                    w_overflow_nxt  = 1'b0;
                    w_underflow_nxt = 1'b0;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_RUN;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_count     <= w_count_nxt;
            r_overflow  <= w_overflow_nxt;
            r_underflow <= w_underflow_nxt;
        end
    end

    stack_regfile #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clock  (clock),
        .we     (w_we & ~reset),
        .waddr  (w_waddr),
        .wdata  (bus.data_in),
        .raddr0 (w_raddr0),
        .raddr1 (w_raddr1),
        .rdata0 (w_rdata0),
        .rdata1 (w_rdata1)
    );

    assign bus.top       = w_empty ? '0 : w_rdata0;
    assign bus.count     = r_count;
    assign bus.empty     = w_empty;
    assign bus.full      = w_full;
    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;
    assign bus.err       = (r_state == ST_ERROR);

`ifdef STACK_PEEK2_EN
    logic w_nos_valid;
    assign w_nos_valid   = (r_count >= CNT_W'(2));
    assign bus.nos_valid = w_nos_valid;
    assign bus.nos       = w_nos_valid ? w_rdata1 : '0;
`else
    logic w_unused_rdata1;
    assign w_unused_rdata1 = ^w_rdata1;
    assign bus.nos_valid   = 1'b0;
    assign bus.nos         = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stack_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : tb_stack_unit                                              |
// | Purpose  : Directed bench for stack_unit with a queue reference model |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module tb_stack_unit;

`ifdef STACK_PEEK2_EN
    localparam bit PEEK2 = 1'b1;
`else
    localparam bit PEEK2 = 1'b0;
`endif
    localparam int DEPTH = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    stack_unit_if #(.DATA_W(16), .CNT_W(5)) bus ();

    stack_unit #(.DATA_W(16), .DEPTH(DEPTH), .CNT_W(5)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference: plain LIFO queue plus error/flag bits
    logic [15:0] q[$];
    bit          m_err = 1'b0;
    bit          m_ovf = 1'b0;
    bit          m_udf = 1'b0;
    bit          compare_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_update(input int rst, input int p, input int o,
                                         input int d, input int clr);
        if (rst != 0) begin
            q.delete();
            m_err = 1'b0;
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else if (m_err) begin
            if (clr != 0) begin
                m_err = 1'b0;
                m_ovf = 1'b0;
                m_udf = 1'b0;
            end
        end else begin
            if (clr != 0) begin
                m_ovf = 1'b0;
                m_udf = 1'b0;
            end
            if (p != 0 && o != 0) begin
                if (q.size() == 0) begin
                    q.push_back(d[15:0]);
                    m_udf = 1'b1;
                    m_err = 1'b1;
                end else begin
                    q[q.size()-1] = d[15:0];
                end
            end else if (p != 0) begin
                if (q.size() == DEPTH) begin
                    m_ovf = 1'b1;
                    m_err = 1'b1;
                end else begin
                    q.push_back(d[15:0]);
                end
            end else if (o != 0) begin
                if (q.size() == 0) begin
                    m_udf = 1'b1;
                    m_err = 1'b1;
                end else begin
                    void'(q.pop_back());
                end
            end
        end
    endfunction

    task automatic step(input int p, input int o, input int d, input int clr, input int rst);
        bus.push      = p[0];
        bus.pop       = o[0];
        bus.data_in   = d[15:0];
        bus.clear_err = clr[0];
        reset         = rst[0];
        @(posedge clock);
        model_update(rst, p, o, d, clr);
        #1;
    endtask

    always @(negedge clock) begin
        if (compare_on) begin
            int          n;
            logic [15:0] e_top;
            logic [15:0] e_nos;
            bit          e_nv;
            n     = q.size();
            e_top = (n > 0) ? q[n-1] : 16'h0;
            e_nv  = PEEK2 && (n >= 2);
            e_nos = e_nv ? q[n-2] : 16'h0;
            chk("top",       32'(bus.top),       32'(e_top));
            chk("nos",       32'(bus.nos),       32'(e_nos));
            chk("nos_valid", 32'(bus.nos_valid), 32'(e_nv));
            chk("count",     32'(bus.count),     n);
            chk("empty",     32'(bus.empty),     32'(n == 0));
            chk("full",      32'(bus.full),      32'(n == DEPTH));
            chk("overflow",  32'(bus.overflow),  32'(m_ovf));
            chk("underflow", 32'(bus.underflow), 32'(m_udf));
            chk("err",       32'(bus.err),       32'(m_err));
        end
    end

    initial begin
        logic [15:0] exp_nos;
        bus.push = 1'b0; bus.pop = 1'b0; bus.data_in = '0; bus.clear_err = 1'b0;
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        compare_on = 1'b1;
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_top",   32'(bus.top),   0);
        chk("rst_empty", 32'(bus.empty), 1);
        chk("rst_err",   32'(bus.err),   0);

        step(1, 0, 16'h0005, 0, 0);
        step(1, 0, 16'h1234, 0, 0);
        exp_nos = PEEK2 ? 16'h0005 : 16'h0000;
        chk("push2_count", 32'(bus.count), 2);
        chk("push2_top",   32'(bus.top),   32'h1234);
        chk("push2_nos",   32'(bus.nos),   32'(exp_nos));
        chk("push2_empty", 32'(bus.empty), 0);

        step(1, 1, 16'h00FF, 0, 0);
        chk("repl_top",   32'(bus.top),   32'h00FF);
        chk("repl_count", 32'(bus.count), 2);
        chk("repl_nos",   32'(bus.nos),   32'(exp_nos));

        step(0, 1, 0, 0, 0);
        chk("pop1_top", 32'(bus.top), 32'h0005);
        step(0, 1, 0, 0, 0);
        chk("pop2_count", 32'(bus.count), 0);
        chk("pop2_empty", 32'(bus.empty), 1);
        chk("pop2_top",   32'(bus.top),   0);
        step(0, 1, 0, 0, 0);
        chk("udf_flag",  32'(bus.underflow), 1);
        chk("udf_err",   32'(bus.err),       1);
        chk("udf_count", 32'(bus.count),     0);

        step(1, 0, 16'hAAAA, 0, 0);
        chk("err_push_ignored", 32'(bus.count), 0);
        step(0, 0, 0, 1, 0);
        chk("clr_err", 32'(bus.err),       0);
        chk("clr_udf", 32'(bus.underflow), 0);
        step(1, 0, 16'hAAAA, 0, 0);
        chk("post_clr_top",   32'(bus.top),   32'hAAAA);
        chk("post_clr_count", 32'(bus.count), 1);

        step(0, 1, 0, 0, 0);
        for (int i = 1; i <= 16; i++) step(1, 0, i, 0, 0);
        chk("fill_full", 32'(bus.full), 1);
        chk("fill_top",  32'(bus.top),  32'h0010);
        step(1, 0, 16'h0099, 0, 0);
        chk("ovf_flag",  32'(bus.overflow), 1);
        chk("ovf_top",   32'(bus.top),      32'h0010);
        chk("ovf_count", 32'(bus.count),    16);
        step(0, 0, 0, 1, 0);
        chk("ovf_clr", 32'(bus.overflow), 0);

        for (int i = 0; i < 13; i++) step(0, 1, 0, 0, 0);
        chk("drain_count", 32'(bus.count), 3);
        chk("drain_top",   32'(bus.top),   3);
        step(1, 0, 16'h0077, 0, 1);
        chk("rst_mid_count", 32'(bus.count), 0);
        chk("rst_mid_err",   32'(bus.err),   0);

        // Replace on an empty stack still pushes but faults
        step(1, 1, 16'h4242, 0, 0);
        chk("repl_empty_count", 32'(bus.count),     1);
        chk("repl_empty_top",   32'(bus.top),       32'h4242);
        chk("repl_empty_udf",   32'(bus.underflow), 1);
        step(0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0);
        // Fault and clear in the same RUN cycle: fault wins
        step(0, 1, 0, 1, 0);
        chk("fault_wins_udf", 32'(bus.underflow), 1);
        chk("fault_wins_err", 32'(bus.err),       1);
        step(0, 0, 0, 1, 0);
        step(1, 0, 16'hBEEF, 1, 0);
        step(1, 0, 16'hCAFE, 0, 0);
        step(0, 0, 0, 0, 0);
        compare_on = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
